// File: rtl/seg7_pkg.sv
// Shared constants and types for the RGB level readout on the 4-digit 7-segment display.
package seg7_pkg;

  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_G  = 8'h47;
  localparam logic [7:0] CH_B  = 8'h42;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_0  = 8'h30;

  typedef enum logic [1:0] {
    CHAN_R    = 2'd0,
    CHAN_G    = 2'd1,
    CHAN_B    = 2'd2,
    CHAN_NONE = 2'd3
  } chan_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  function automatic logic [7:0] chan_letter(input chan_e c);
    case (c)
      CHAN_R:  return CH_R;
      CHAN_G:  return CH_G;
      CHAN_B:  return CH_B;
      default: return CH_SP;
    endcase
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return CH_0 + {4'd0, d};
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Sequential double-dabble: 8-bit binary to 3-digit BCD, one bit per cycle.
module bin2bcd8
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  din,
  output logic        done,
  output logic [11:0] bcd
);

  logic [7:0]  shift_reg;
  logic [11:0] bcd_reg;
  logic [2:0]  cnt_reg;
  logic        run_reg;
  logic [7:0]  adj;

  // Only tens and ones need the add-3 step: hundreds never reaches 5 for 8-bit input.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                            : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      run_reg   <= 1'b0;
    end else if (start) begin
      shift_reg <= din;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      run_reg   <= 1'b1;
    end else if (run_reg) begin
      bcd_reg   <= {bcd_reg[10:8], adj, shift_reg[7]};
      shift_reg <= {shift_reg[6:0], 1'b0};
      cnt_reg   <= cnt_reg + 3'd1;
      if (cnt_reg == 3'd7) run_reg <= 1'b0;
    end
  end

  // Strobes during the cycle whose closing edge performs the final iteration.
  assign done = run_reg && (cnt_reg == 3'd7);
  assign bcd  = bcd_reg;

endmodule

// File: rtl/seg7_rgb_scan.sv
// Converts a channel/level pair to a 4-char ASCII string and scans it across
// the four active-low anodes, one character per refresh slot.
module seg7_rgb_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [1:0] chan,
  input  logic [7:0] value,
  output logic       busy,
  output logic [7:0] ch,
  output logic [3:0] an
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  state_e      state_reg, state_next;
  chan_e       chan_reg;
  logic        start;
  logic        done;
  logic [11:0] bcd;
  logic [7:0]  txt_reg  [4];
  logic [7:0]  txt_next [4];
  logic [DIV_W-1:0] div_reg, div_next;
  logic [1:0]  idx_reg, idx_next;

  bin2bcd8 u_bin2bcd8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (value),
    .done  (done),
    .bcd   (bcd)
  );

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          start      = 1'b1;
          state_next = CONV;
        end
      end
      CONV:    if (done) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      chan_reg  <= CHAN_R;
    end else begin
      state_reg <= state_next;
      if (start) chan_reg <= chan_e'(chan);
    end
  end

  assign busy = (state_reg != IDLE);

  // Leading-zero blanking: the ones digit is always shown.
  always_comb begin
    for (int i = 0; i < 4; i++) txt_next[i] = txt_reg[i];
    if (state_reg == COMMIT) begin
      txt_next[0] = chan_letter(chan_reg);
      txt_next[1] = (bcd[11:8] == 4'd0) ? CH_SP : digit_char(bcd[11:8]);
      txt_next[2] = (bcd[11:4] == 8'd0) ? CH_SP : digit_char(bcd[7:4]);
      txt_next[3] = digit_char(bcd[3:0]);
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_txt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) txt_reg[gi] <= CH_SP;
        else        txt_reg[gi] <= txt_next[gi];
      end
    end
  endgenerate

  always_comb begin
    div_next = div_reg + DIV_W'(1);
    idx_next = idx_reg;
    if (div_reg == DIV_W'(REFRESH_DIV - 1)) begin
      div_next = '0;
      idx_next = idx_reg + 2'd1;
    end
  end

  // Outputs are built from the next-state index and text so a commit landing on
  // a slot boundary shows up in the new slot together with its anode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= '0;
      idx_reg <= '0;
      an      <= 4'b0111;
      ch      <= CH_SP;
    end else begin
      div_reg <= div_next;
      idx_reg <= idx_next;
      an      <= ~(4'b1000 >> idx_next);
      ch      <= txt_next[idx_next];
    end
  end

endmodule

// File: tb/tb_seg7_rgb_scan.sv
// Self-checking bench: table-driven loads, a commit scoreboard and a per-cycle scan monitor.
module tb_seg7_rgb_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load;
  logic [1:0] chan;
  logic [7:0] value;
  logic       busy;
  logic [7:0] ch;
  logic [3:0] an;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  logic prev_busy = 1'b0;
  logic [7:0]  model [4];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [1:0]  c;
    logic [7:0]  v;
    logic [31:0] e;
  } vec_t;
  vec_t vecs [6];

  seg7_rgb_scan #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .chan  (chan),
    .value (value),
    .busy  (busy),
    .ch    (ch),
    .an    (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) cyc++;
    else       cyc = 0;
  end

  // Scan monitor and commit scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    int idx;
    if (!rst_n) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else if (cyc > 0) begin
      if (busy) busy_cnt++;
      else if (prev_busy) begin
        check("busy_len", busy_cnt, 9);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_commit: busy pulse with no pending load");
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 4; i++) model[i] = e[31-8*i -: 8];
          $display("commit \"%s\" busy_cycles=%0d", e, busy_cnt);
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
      idx = (cyc / 4) % 4;
      check("an", {28'd0, an}, {28'd0, ~(4'b1000 >> idx)});
      check("ch", {24'd0, ch}, {24'd0, model[idx]});
    end
  end

  // Call at a negedge; returns one negedge later with load released.
  task automatic drive_load(input logic [1:0] c, input logic [7:0] v, input logic [31:0] e);
    load  = 1'b1;
    chan  = c;
    value = v;
    exp_q.push_back(e);
    @(negedge clk);
    load = 1'b0;
    check("load_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle();
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    check("idle_timeout", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{c: 2'd0, v: 8'd255, e: "R255"};
    vecs[1] = '{c: 2'd1, v: 8'd7,   e: "G  7"};
    vecs[2] = '{c: 2'd2, v: 8'd100, e: "B100"};
    vecs[3] = '{c: 2'd3, v: 8'd0,   e: "   0"};
    vecs[4] = '{c: 2'd1, v: 8'd50,  e: "G 50"};
    vecs[5] = '{c: 2'd2, v: 8'd209, e: "B209"};
    for (int i = 0; i < 4; i++) model[i] = 8'h20;
    load = 1'b0; chan = 2'd0; value = 8'd0;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_an", {28'd0, an}, 32'h7);
    check("rst_ch", {24'd0, ch}, 32'h20);
    rst_n = 1'b1;

    // Idle scanning with a blank buffer.
    repeat (20) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_load(vecs[i].c, vecs[i].v, vecs[i].e);
      wait_idle();
      repeat (16) @(negedge clk);
    end

    // A load during conversion is dropped.
    @(negedge clk);
    drive_load(2'd0, 8'd42, "R 42");
    repeat (2) @(negedge clk);
    load = 1'b1; chan = 2'd1; value = 8'd9;
    @(negedge clk);
    load = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    // Reset in the fifth conversion cycle aborts without committing.
    @(negedge clk);
    drive_load(2'd0, 8'd200, "R200");
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_an", {28'd0, an}, 32'h7);
    check("abort_ch", {24'd0, ch}, 32'h20);
    exp_q.delete();
    for (int i = 0; i < 4; i++) model[i] = 8'h20;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (24) @(negedge clk);

    // Back-to-back loads on the first idle cycle.
    @(negedge clk);
    drive_load(2'd0, 8'd0, "R  0");
    wait_idle();
    drive_load(2'd0, 8'd99, "R 99");
    wait_idle();
    repeat (16) @(negedge clk);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
